// File: rtl/ahb_burst_master_if.sv
// ahb_burst_master_if: command, write/read data and AHB-Lite master signal bundle.
// Carries ahb_resp only when AHB_MST_HRESP_EN is defined.
interface ahb_burst_master_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
   logic              cmd_valid, cmd_ready, cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [2:0]        cmd_size, cmd_burst;
   logic [DATA_W-1:0] wd_data;
   logic              wd_pop;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid, rd_last, cmd_done, cmd_err;
   logic              ahb_readyi;
   logic [DATA_W-1:0] ahb_rdata;
   logic              ahb_write;
   logic [ADDR_W-1:0] ahb_addr;
   logic [DATA_W-1:0] ahb_wdata;
   logic [1:0]        ahb_trans;
   logic [2:0]        ahb_size, ahb_burst;
`ifdef AHB_MST_HRESP_EN
   logic              ahb_resp;
`endif
   modport master (
`ifdef AHB_MST_HRESP_EN
      input  ahb_resp,
`endif
      input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_burst, wd_data, ahb_readyi, ahb_rdata,
      output cmd_ready, wd_pop, rd_data, rd_valid, rd_last, cmd_done, cmd_err,
             ahb_write, ahb_addr, ahb_wdata, ahb_trans, ahb_size, ahb_burst
   );
   modport slave (
`ifdef AHB_MST_HRESP_EN
      output ahb_resp,
`endif
      output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_burst, wd_data, ahb_readyi, ahb_rdata,
      input  cmd_ready, wd_pop, rd_data, rd_valid, rd_last, cmd_done, cmd_err,
             ahb_write, ahb_addr, ahb_wdata, ahb_trans, ahb_size, ahb_burst
   );
endinterface

// File: rtl/ahb_burst_master.sv
// ahb_burst_master: AHB-Lite master issuing SINGLE/INCR4/INCR8 bursts with pipelined beats.
// Define AHB_MST_HRESP_EN to add ahb_resp error handling (cancel burst, cmd_err on completion).
module ahb_burst_master #(parameter int ADDR_W = 32, parameter int DATA_W = 32) (
   input  logic               hclk,
   input  logic               rst_n,
   ahb_burst_master_if.master bus
);
   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_BURST, S_LAST} state_t;
   state_t            state;
   logic [2:0]        cnt, sz, bt;
   logic              cw, err, rsp;
   logic [ADDR_W-1:0] step;
`ifdef AHB_MST_HRESP_EN
   assign rsp = bus.ahb_resp;
`else
   assign rsp = 1'b0;
`endif
   always_comb sz = (bus.cmd_size < 3'd3 || (bus.cmd_size == 3'd3 && DATA_W == 64)) ? bus.cmd_size : 3'd2;
   always_comb bt = (bus.cmd_burst == 3'b011 || bus.cmd_burst == 3'b101) ? bus.cmd_burst : 3'b000;
   assign step = ADDR_W'(1) << bus.ahb_size;
   assign bus.cmd_ready = state == S_IDLE;
   assign bus.wd_pop = (state == S_ADDR || state == S_BURST) && bus.ahb_write && bus.ahb_readyi;
   always_ff @(posedge hclk or negedge rst_n)
      if (!rst_n) begin
         state <= S_IDLE;
         cnt <= '0;
         cw <= 1'b0;
         err <= 1'b0;
         bus.ahb_trans <= 2'b00;
         bus.ahb_addr <= '0;
         bus.ahb_write <= 1'b0;
         bus.ahb_wdata <= '0;
         bus.ahb_size <= 3'b000;
         bus.ahb_burst <= 3'b000;
         bus.rd_data <= '0;
         bus.rd_valid <= 1'b0;
         bus.rd_last <= 1'b0;
         bus.cmd_done <= 1'b0;
         bus.cmd_err <= 1'b0;
      end else begin
         bus.rd_valid <= 1'b0;
         bus.rd_last <= 1'b0;
         bus.cmd_done <= 1'b0;
         bus.cmd_err <= 1'b0;
         case (state)
            S_IDLE: if (bus.cmd_valid) begin
               state <= S_ADDR;
               cw <= bus.cmd_write;
               err <= 1'b0;
               cnt <= bt == 3'b011 ? 3'd3 : bt == 3'b101 ? 3'd7 : 3'd0;
               bus.ahb_trans <= 2'b10;
               bus.ahb_addr <= bus.cmd_addr & ~((ADDR_W'(1) << sz) - ADDR_W'(1));
               bus.ahb_write <= bus.cmd_write;
               bus.ahb_size <= sz;
               bus.ahb_burst <= bt;
            end
            // an error's first cycle (HREADY low) also exits here, abandoning the pending address
            S_ADDR, S_BURST: if (bus.ahb_readyi || (state == S_BURST && rsp)) begin
               if (bus.ahb_readyi && state == S_BURST && !cw) begin
                  bus.rd_data <= bus.ahb_rdata;
                  bus.rd_valid <= 1'b1;
               end
               if (bus.ahb_readyi && cw) bus.ahb_wdata <= bus.wd_data;
               err <= !bus.ahb_readyi;
               if (!bus.ahb_readyi || cnt == 3'd0) begin
                  state <= S_LAST;
                  bus.ahb_trans <= 2'b00;
                  bus.ahb_addr <= '0;
                  bus.ahb_write <= 1'b0;
                  bus.ahb_size <= 3'b000;
                  bus.ahb_burst <= 3'b000;
               end else begin
                  state <= S_BURST;
                  bus.ahb_trans <= 2'b11;
                  bus.ahb_addr <= bus.ahb_addr + step;
                  cnt <= cnt - 3'd1;
               end
            end
            S_LAST: if (bus.ahb_readyi) begin
               state <= S_IDLE;
               bus.cmd_done <= 1'b1;
               bus.cmd_err <= err | rsp;
               bus.ahb_wdata <= '0;
               if (!cw && !(err | rsp)) begin
                  bus.rd_data <= bus.ahb_rdata;
                  bus.rd_valid <= 1'b1;
                  bus.rd_last <= 1'b1;
               end
            end else if (rsp) err <= 1'b1;
            default: state <= S_IDLE;
         endcase
      end
endmodule
